// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction buffer between fetch and decode. Holds up to
//                DEPTH {instr, pc, fault} entries in program order and
//                presents the oldest one to decode (first-word fall-through).
//                A redirect discards every buffered entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redir_i,
    input  logic                   fq_in_valid,
    output logic                   fq_in_ready,
    input  logic [XLEN-1:0]        fq_in_instr,
    input  logic [XLEN-1:0]        fq_in_pc,
    input  logic                   fq_in_fault,
    output logic                   instr_valid,
    input  logic                   dec_ready,
    output logic [XLEN-1:0]        instr_i,
    output logic [XLEN-1:0]        pc_o,
    output logic                   fault_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int               C_AW       = $clog2(DEPTH);
    localparam int               C_PW       = C_AW + 1;
    localparam logic [C_PW-1:0]  C_PTR_ZERO = '0;
    localparam logic [C_PW-1:0]  C_PTR_ONE  = C_PW'(1);
    localparam logic [XLEN-1:0]  C_NOP      = XLEN'(32'h0000_0013);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [C_PW-1:0] r_wr_ptr;
    logic [C_PW-1:0] r_rd_ptr;

    // Payload storage; deliberately not reset, only the pointers are.
    logic [XLEN-1:0] r_instr_mem [DEPTH];
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic            r_fault_mem [DEPTH];

    logic            w_full;
    logic            w_empty;
    logic            w_enq;
    logic            w_deq;
    logic [C_AW-1:0] w_wr_idx;
    logic [C_AW-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[C_AW-1:0];
    assign w_rd_idx = r_rd_ptr[C_AW-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) && (w_wr_idx == w_rd_idx);

    // Both handshakes are gated by reset and redirect; ready ignores dec_ready.
    assign fq_in_ready = rst && !redir_i && !w_full;
    assign instr_valid = rst && !redir_i && !w_empty;
    assign w_enq       = fq_in_valid && fq_in_ready;
    assign w_deq       = instr_valid && dec_ready;

    // Occupancy follows directly from the pointer distance.
    assign count_o = r_wr_ptr - r_rd_ptr;

    // Pointer update: reset has priority over redirect, redirect over traffic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= C_PTR_ZERO;
            r_rd_ptr <= C_PTR_ZERO;
        end else if (redir_i) begin
            r_wr_ptr <= C_PTR_ZERO;
            r_rd_ptr <= C_PTR_ZERO;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // Payload write at the write pointer on every accepted entry.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_instr_mem[w_wr_idx] <= fq_in_instr;
            r_pc_mem[w_wr_idx]    <= fq_in_pc;
            r_fault_mem[w_wr_idx] <= fq_in_fault;
        end
    end

    // Head presentation; a NOP with zero PC/fault is shown whenever invalid.
    always_comb begin
        instr_i = C_NOP;
        pc_o    = '0;
        fault_o = 1'b0;
        if (instr_valid) begin
            instr_i = r_instr_mem[w_rd_idx];
            pc_o    = r_pc_mem[w_rd_idx];
            fault_o = r_fault_mem[w_rd_idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Scoreboard bench for fetch_queue. The driver pushes each
//                accepted entry into an expected queue; a negedge monitor
//                compares the DUT head against it and pops on dequeue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        redir_i;
    logic        fq_in_valid;
    logic        fq_in_ready;
    logic [31:0] fq_in_instr;
    logic [31:0] fq_in_pc;
    logic        fq_in_fault;
    logic        instr_valid;
    logic        dec_ready;
    logic [31:0] instr_i;
    logic [31:0] pc_o;
    logic        fault_o;
    logic [2:0]  count_o;

    entry_t exp_q[$];
    int     n_pass;
    int     n_total;
    int     pop_cnt;
    logic   tb_active;
    logic   toggle_ready;
    logic   last_fired;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .redir_i     (redir_i),
        .fq_in_valid (fq_in_valid),
        .fq_in_ready (fq_in_ready),
        .fq_in_instr (fq_in_instr),
        .fq_in_pc    (fq_in_pc),
        .fq_in_fault (fq_in_fault),
        .instr_valid (instr_valid),
        .dec_ready   (dec_ready),
        .instr_i     (instr_i),
        .pc_o        (pc_o),
        .fault_o     (fault_o),
        .count_o     (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: compare head and handshake signals against the scoreboard model.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
            chk("rst_fq_in_ready", {31'd0, fq_in_ready}, 32'd0);
            chk("rst_instr_nop", instr_i, 32'h13);
        end else if (tb_active) begin
            chk("count", {29'd0, count_o}, exp_q.size());
            chk("instr_valid", {31'd0, instr_valid}, {31'd0, (!redir_i && exp_q.size() != 0)});
            chk("fq_in_ready", {31'd0, fq_in_ready}, {31'd0, (!redir_i && exp_q.size() < DEPTH)});
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL head: got pc %h expected no valid entry", pc_o);
                end else begin
                    chk("head_pc", pc_o, exp_q[0].pc);
                    chk("head_instr", instr_i, exp_q[0].instr);
                    chk("head_fault", {31'd0, fault_o}, {31'd0, exp_q[0].fault});
                    if (dec_ready) begin
                        void'(exp_q.pop_front());
                        pop_cnt++;
                    end
                end
            end else begin
                chk("idle_instr_nop", instr_i, 32'h13);
                chk("idle_pc_zero", pc_o, 32'd0);
                chk("idle_fault_zero", {31'd0, fault_o}, 32'd0);
            end
        end
    end

    // One clock: sample the handshake mid-cycle, then update the model after the edge.
    task automatic step();
        logic fired;
        logic flushed;
        @(negedge clk);
        fired   = fq_in_valid && fq_in_ready;
        flushed = rst && redir_i;
        @(posedge clk);
        #1;
        if (flushed) exp_q.delete();
        if (fired) exp_q.push_back('{instr: fq_in_instr, pc: fq_in_pc, fault: fq_in_fault});
        last_fired = fired;
        if (toggle_ready) dec_ready = ~dec_ready;
    endtask

    // Present one entry and hold it until accepted; valid stays high afterwards.
    task automatic send(input logic [31:0] pc, input logic fault);
        int n;
        fq_in_valid = 1'b1;
        fq_in_pc    = pc;
        fq_in_instr = {pc[15:0], 16'h0033};
        fq_in_fault = fault;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_fired && n < 50);
        if (!last_fired) begin
            n_total++;
            $display("FAIL send_timeout: pc %h not accepted within %0d cycles", pc, n);
        end
    endtask

    task automatic drain();
        fq_in_valid = 1'b0;
        dec_ready   = 1'b1;
        for (int i = 0; i < 8; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0; pop_cnt = 0;
        tb_active = 1'b0; toggle_ready = 1'b0; last_fired = 1'b0;
        rst = 1'b0; redir_i = 1'b0; dec_ready = 1'b0;
        fq_in_valid = 1'b1; fq_in_pc = 32'h40; fq_in_instr = 32'hdead; fq_in_fault = 1'b0;

        // 1: reset held three cycles with fetch requesting
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1; fq_in_valid = 1'b0;
        exp_q.delete();
        tb_active = 1'b1;
        #1;
        chk("release_count", {29'd0, count_o}, 32'd0);
        chk("release_ready", {31'd0, fq_in_ready}, 32'd1);

        // 2: fill to capacity, refuse a fifth, then drain in order
        send(32'h100, 1'b0);
        send(32'h104, 1'b0);
        send(32'h108, 1'b0);
        send(32'h10C, 1'b0);
        chk("full_count", {29'd0, count_o}, 32'd4);
        chk("full_ready", {31'd0, fq_in_ready}, 32'd0);
        fq_in_pc = 32'h110; fq_in_instr = 32'h0110_0033;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fifth_refused", {31'd0, last_fired}, 32'd0);
        end
        pop_cnt = 0;
        fq_in_valid = 1'b0; dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_pops", pop_cnt, 32'd4);
        chk("drain_empty", {31'd0, instr_valid}, 32'd0);

        // 3: ten-entry stream with dec_ready toggling every cycle
        pop_cnt = 0;
        dec_ready = 1'b0; toggle_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(32'h1000 + 32'(i * 4), 1'b0);
        toggle_ready = 1'b0;
        drain();
        chk("wrap_pops", pop_cnt, 32'd10);

        // 4: simultaneous enqueue and dequeue at count 2
        dec_ready = 1'b0;
        send(32'hA00, 1'b0);
        send(32'hA04, 1'b0);
        fq_in_valid = 1'b0;
        step();
        chk("sim_pre_count", {29'd0, count_o}, 32'd2);
        dec_ready = 1'b1;
        fq_in_valid = 1'b1; fq_in_pc = 32'hA08; fq_in_instr = 32'h0A08_0033; fq_in_fault = 1'b0;
        step();
        chk("sim_fired", {31'd0, last_fired}, 32'd1);
        chk("sim_count", {29'd0, count_o}, 32'd2);
        chk("sim_head", pc_o, 32'hA04);
        drain();

        // 5: flush with three buffered entries and a competing enqueue
        dec_ready = 1'b0;
        send(32'h180, 1'b0);
        send(32'h184, 1'b0);
        send(32'h188, 1'b0);
        pop_cnt = 0;
        redir_i = 1'b1; dec_ready = 1'b1;
        fq_in_pc = 32'h200; fq_in_instr = 32'h0200_0033; fq_in_fault = 1'b0;
        step();
        chk("flush_no_enq", {31'd0, last_fired}, 32'd0);
        chk("flush_no_deq", pop_cnt, 32'd0);
        redir_i = 1'b0; dec_ready = 1'b0;
        chk("flush_count", {29'd0, count_o}, 32'd0);
        chk("flush_valid", {31'd0, instr_valid}, 32'd0);
        send(32'h200, 1'b0);
        fq_in_valid = 1'b0;
        chk("redir_visible", {31'd0, instr_valid}, 32'd1);
        chk("redir_pc", pc_o, 32'h200);
        drain();

        // 6: fault bit follows its own entry only
        dec_ready = 1'b0;
        send(32'h2FC, 1'b0);
        send(32'h300, 1'b1);
        send(32'h304, 1'b0);
        drain();
        chk("final_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
